dmi_stub_target: RTL and testbench

DMI_STUB_TARGET -- requirements
Module: dmi_stub_target

---
 rtl/dmi_stub_target.sv | 189 ++++++++++++++++++
 tb/tb_dmi_stub_target.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmi_stub_target.sv
// Minimal DMI target: small register file behind a valid/ready request channel,
// fixed response latency, one outstanding request at a time.
module dmi_stub_target #(
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        debug_req_valid,
  output logic        debug_req_ready,
  input  logic [6:0]  debug_req_bits_addr,
  input  logic [1:0]  debug_req_bits_op,
  input  logic [31:0] debug_req_bits_data,
  output logic        debug_resp_valid,
  input  logic        debug_resp_ready,
  output logic [1:0]  debug_resp_bits_resp,
  output logic [31:0] debug_resp_bits_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [7:0]  LAT        = 8'(LATENCY);
  localparam logic [1:0]  OP_NOP     = 2'd0;
  localparam logic [1:0]  OP_READ    = 2'd1;
  localparam logic [1:0]  OP_WRITE   = 2'd2;
  localparam logic [1:0]  RESP_OK    = 2'd0;
  localparam logic [1:0]  RESP_FAIL  = 2'd2;
  localparam logic [31:0] STATUS_VAL = 32'h0000_0002;

  state_e      state_q, state_d;
  logic [7:0]  countdown_q, countdown_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [1:0]  resp_q, resp_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] data_q [4];
  logic [31:0] data_d [4];
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] reqcount_q, reqcount_d;

  logic        req_fire;
  logic        resp_fire;
  logic [31:0] rd_val;

  assign req_fire  = debug_req_valid & req_ready_q;
  assign resp_fire = resp_valid_q & debug_resp_ready;

  assign debug_req_ready      = req_ready_q;
  assign debug_resp_valid     = resp_valid_q;
  assign debug_resp_bits_resp = resp_q;
  assign debug_resp_bits_data = rdata_q;

  // Register read mux; reqcount yields its value before this request's increment.
  always_comb begin
    rd_val = 32'h0000_0000;
    case (debug_req_bits_addr)
      7'h04:   rd_val = data_q[0];
      7'h05:   rd_val = data_q[1];
      7'h06:   rd_val = data_q[2];
      7'h07:   rd_val = data_q[3];
      7'h10:   rd_val = scratch_q;
      7'h11:   rd_val = STATUS_VAL;
      7'h38:   rd_val = reqcount_q;
      default: rd_val = 32'h0000_0000;
    endcase
  end

  // Next-state logic for the handshake FSM, register file and response holding regs.
  always_comb begin
    state_d      = state_q;
    countdown_d  = countdown_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_d       = resp_q;
    rdata_d      = rdata_q;
    for (int i = 0; i < 4; i++) begin
      data_d[i] = data_q[i];
    end
    scratch_d    = scratch_q;
    reqcount_d   = reqcount_q;

    case (state_q)
      IDLE: begin
        if (req_fire) begin
          req_ready_d = 1'b0;
          if (debug_req_bits_op != OP_NOP) begin
            reqcount_d = reqcount_q + 32'd1;
          end else begin
            reqcount_d = reqcount_q;
          end
          case (debug_req_bits_op)
            OP_READ: begin
              resp_d  = RESP_OK;
              rdata_d = rd_val;
            end
            OP_WRITE: begin
              resp_d  = RESP_OK;
              rdata_d = 32'h0000_0000;
              case (debug_req_bits_addr)
                7'h04:   data_d[0] = debug_req_bits_data;
                7'h05:   data_d[1] = debug_req_bits_data;
                7'h06:   data_d[2] = debug_req_bits_data;
                7'h07:   data_d[3] = debug_req_bits_data;
                7'h10:   scratch_d = debug_req_bits_data;
                default: scratch_d = scratch_q;
              endcase
            end
            OP_NOP: begin
              resp_d  = RESP_OK;
              rdata_d = 32'h0000_0000;
            end
            default: begin
              resp_d  = RESP_FAIL;
              rdata_d = 32'h0000_0000;
            end
          endcase
          if (LAT == 8'd0) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            countdown_d  = 8'd0;
          end else begin
            state_d      = WAIT;
            countdown_d  = LAT;
          end
        end else begin
          req_ready_d = 1'b1;
        end
      end
      WAIT: begin
        if (countdown_q <= 8'd1) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          countdown_d  = 8'd0;
        end else begin
          countdown_d  = countdown_q - 8'd1;
        end
      end
      RESP: begin
        // Ready returns only after the response handshake edge.
        if (resp_fire) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
        end else begin
          resp_valid_d = 1'b1;
        end
      end
      default: begin
        state_d      = IDLE;
        req_ready_d  = 1'b0;
        resp_valid_d = 1'b0;
        countdown_d  = 8'd0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      countdown_q  <= 8'd0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_q       <= 2'd0;
      rdata_q      <= 32'h0000_0000;
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= 32'h0000_0000;
      end
      scratch_q    <= 32'h0000_0000;
      reqcount_q   <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      countdown_q  <= countdown_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_q       <= resp_d;
      rdata_q      <= rdata_d;
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= data_d[i];
      end
      scratch_q    <= scratch_d;
      reqcount_q   <= reqcount_d;
    end
  end

endmodule

// File: tb/tb_dmi_stub_target.sv
// Directed bench for dmi_stub_target: one instance with LATENCY=2, one with LATENCY=0,
// expected responses queued at request time and compared when the response appears.
module tb_dmi_stub_target;

  localparam int LAT0 = 2;
  localparam int LAT1 = 0;

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        reset      [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic [6:0]  req_addr   [2];
  logic [1:0]  req_op     [2];
  logic [31:0] req_data   [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [1:0]  resp_resp  [2];
  logic [31:0] resp_data  [2];

  exp_t sb_q[$];
  int   n_pass;
  int   n_total;

  dmi_stub_target #(.LATENCY(LAT0)) u_dut2 (
    .clk                  (clk),
    .reset                (reset[0]),
    .debug_req_valid      (req_valid[0]),
    .debug_req_ready      (req_ready[0]),
    .debug_req_bits_addr  (req_addr[0]),
    .debug_req_bits_op    (req_op[0]),
    .debug_req_bits_data  (req_data[0]),
    .debug_resp_valid     (resp_valid[0]),
    .debug_resp_ready     (resp_ready[0]),
    .debug_resp_bits_resp (resp_resp[0]),
    .debug_resp_bits_data (resp_data[0])
  );

  dmi_stub_target #(.LATENCY(LAT1)) u_dut0 (
    .clk                  (clk),
    .reset                (reset[1]),
    .debug_req_valid      (req_valid[1]),
    .debug_req_ready      (req_ready[1]),
    .debug_req_bits_addr  (req_addr[1]),
    .debug_req_bits_op    (req_op[1]),
    .debug_req_bits_data  (req_data[1]),
    .debug_resp_valid     (resp_valid[1]),
    .debug_resp_ready     (resp_ready[1]),
    .debug_resp_bits_resp (resp_resp[1]),
    .debug_resp_bits_data (resp_data[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int i);
    return (i == 0) ? LAT0 : LAT1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic [1:0] op,
                       input logic [6:0] a, input logic [31:0] d);
    req_valid[i] = v;
    req_op[i]    = op;
    req_addr[i]  = a;
    req_data[i]  = d;
  endtask

  task automatic push_exp(input logic [1:0] er, input logic [31:0] ed);
    exp_t e;
    e.resp = er;
    e.data = ed;
    sb_q.push_back(e);
  endtask

  task automatic pop_cmp(input int i, input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({tag, "/sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check({tag, "/resp"}, {30'd0, resp_resp[i]}, {30'd0, e.resp});
      check({tag, "/data"}, resp_data[i], e.data);
    end
  endtask

  // Issue a request and wait until it is accepted; expected result is queued first.
  task automatic send(input int i, input logic [1:0] op, input logic [6:0] a,
                      input logic [31:0] d, input logic [1:0] er, input logic [31:0] ed,
                      input string tag);
    int n;
    push_exp(er, ed);
    drive(i, 1'b1, op, a, d);
    n = 0;
    while (req_ready[i] !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check({tag, "/accept"}, 32'(n < 50), 32'd1);
    tick();
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_resp(input int i, input string tag);
    int n;
    n = 0;
    while (resp_valid[i] !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    // cycles counted from the accepting edge, inclusive
    check({tag, "/latency"}, 32'(n + 1), 32'(lat_of(i) + 1));
  endtask

  task automatic do_req(input int i, input logic [1:0] op, input logic [6:0] a,
                        input logic [31:0] d, input logic [1:0] er, input logic [31:0] ed,
                        input string tag);
    resp_ready[i] = 1'b1;
    send(i, op, a, d, er, ed, tag);
    wait_resp(i, tag);
    pop_cmp(i, tag);
    tick();
    check({tag, "/rv_drop"}, {31'd0, resp_valid[i]}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   accepts;
    logic acc;
    logic prev_acc;
    exp_t e;

    n_pass  = 0;
    n_total = 0;
    for (int i = 0; i < 2; i++) begin
      reset[i]      = 1'b1;
      resp_ready[i] = 1'b1;
      drive(i, 1'b0, 2'd0, 7'd0, 32'd0);
    end

    // Reset state
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      check("rst/req_ready", {31'd0, req_ready[i]}, 32'd0);
      check("rst/resp_valid", {31'd0, resp_valid[i]}, 32'd0);
      check("rst/resp", {30'd0, resp_resp[i]}, 32'd0);
      check("rst/data", resp_data[i], 32'd0);
      reset[i] = 1'b0;
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      check("rst/ready_after", {31'd0, req_ready[i]}, 32'd1);
    end

    // Register map and op behaviour on the LATENCY=2 instance
    do_req(0, 2'd2, 7'h04, 32'hDEAD_BEEF, 2'd0, 32'h0000_0000, "wr_data0");
    do_req(0, 2'd1, 7'h04, 32'h0000_0000, 2'd0, 32'hDEAD_BEEF, "rd_data0");
    do_req(0, 2'd3, 7'h10, 32'h0000_1234, 2'd2, 32'h0000_0000, "rsvd_op");
    do_req(0, 2'd1, 7'h10, 32'h0000_0000, 2'd0, 32'h0000_0000, "rd_scratch0");
    do_req(0, 2'd2, 7'h10, 32'hA5A5_0001, 2'd0, 32'h0000_0000, "wr_scratch");
    do_req(0, 2'd1, 7'h10, 32'h0000_0000, 2'd0, 32'hA5A5_0001, "rd_scratch1");
    do_req(0, 2'd0, 7'h10, 32'h0000_0001, 2'd0, 32'h0000_0000, "nop");
    do_req(0, 2'd1, 7'h10, 32'h0000_0000, 2'd0, 32'hA5A5_0001, "rd_scratch2");
    do_req(0, 2'd2, 7'h11, 32'hFFFF_FFFF, 2'd0, 32'h0000_0000, "wr_status");
    do_req(0, 2'd1, 7'h11, 32'h0000_0000, 2'd0, 32'h0000_0002, "rd_status");
    do_req(0, 2'd1, 7'h20, 32'h0000_0000, 2'd0, 32'h0000_0000, "rd_unmapped");
    do_req(0, 2'd2, 7'h07, 32'h1357_2468, 2'd0, 32'h0000_0000, "wr_data3");
    do_req(0, 2'd1, 7'h07, 32'h0000_0000, 2'd0, 32'h1357_2468, "rd_data3");
    do_req(0, 2'd1, 7'h38, 32'h0000_0000, 2'd0, 32'd12, "rd_reqcount");

    // Response back-pressure: response must hold and new requests must be ignored
    resp_ready[0] = 1'b0;
    send(0, 2'd1, 7'h04, 32'h0, 2'd0, 32'hDEAD_BEEF, "hold");
    wait_resp(0, "hold");
    e = sb_q[0];
    drive(0, 1'b1, 2'd2, 7'h04, 32'h0000_0000);
    for (int k = 0; k < 5; k++) begin
      check("hold/resp_valid", {31'd0, resp_valid[0]}, 32'd1);
      check("hold/req_ready", {31'd0, req_ready[0]}, 32'd0);
      check("hold/resp", {30'd0, resp_resp[0]}, {30'd0, e.resp});
      check("hold/data", resp_data[0], e.data);
      tick();
    end
    pop_cmp(0, "hold");
    req_valid[0]  = 1'b0;
    resp_ready[0] = 1'b1;
    tick();
    check("hold/rv_release", {31'd0, resp_valid[0]}, 32'd0);
    check("hold/ready_release", {31'd0, req_ready[0]}, 32'd1);
    do_req(0, 2'd1, 7'h04, 32'h0, 2'd0, 32'hDEAD_BEEF, "rd_after_hold");

    // Reset while the request is waiting: its response must never appear
    drive(0, 1'b1, 2'd2, 7'h06, 32'h0000_0077);
    while (req_ready[0] !== 1'b1) tick();
    tick();
    req_valid[0] = 1'b0;
    check("rstwait/in_wait", {31'd0, resp_valid[0]}, 32'd0);
    reset[0] = 1'b1;
    tick();
    check("rstwait/req_ready", {31'd0, req_ready[0]}, 32'd0);
    check("rstwait/resp_valid", {31'd0, resp_valid[0]}, 32'd0);
    reset[0] = 1'b0;
    tick();
    check("rstwait/ready_after", {31'd0, req_ready[0]}, 32'd1);
    for (int k = 0; k < 6; k++) begin
      check("rstwait/no_resp", {31'd0, resp_valid[0]}, 32'd0);
      tick();
    end
    do_req(0, 2'd1, 7'h38, 32'h0, 2'd0, 32'd0, "rstwait/rd_cnt0");
    do_req(0, 2'd1, 7'h11, 32'h0, 2'd0, 32'h0000_0002, "rstwait/rd_status");
    do_req(0, 2'd1, 7'h38, 32'h0, 2'd0, 32'd2, "rstwait/rd_cnt2");
    do_req(0, 2'd1, 7'h38, 32'h0, 2'd0, 32'd3, "rstwait/rd_cnt3");
    do_req(0, 2'd1, 7'h04, 32'h0, 2'd0, 32'd0, "rstwait/rd_data0");
    do_req(0, 2'd1, 7'h06, 32'h0, 2'd0, 32'd0, "rstwait/rd_data2");
    do_req(0, 2'd1, 7'h07, 32'h0, 2'd0, 32'd0, "rstwait/rd_data3");
    do_req(0, 2'd1, 7'h10, 32'h0, 2'd0, 32'd0, "rstwait/rd_scratch");

    // LATENCY=0 instance: single write then back-to-back reads
    do_req(1, 2'd2, 7'h10, 32'hCAFE_0001, 2'd0, 32'h0, "l0/wr_scratch");
    resp_ready[1] = 1'b1;
    drive(1, 1'b1, 2'd1, 7'h10, 32'h0);
    accepts  = 0;
    prev_acc = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (prev_acc) begin
        check("l0/rv_next_cycle", {31'd0, resp_valid[1]}, 32'd1);
      end
      if (resp_valid[1] === 1'b1) begin
        pop_cmp(1, "l0/b2b");
      end
      acc = req_ready[1] & req_valid[1];
      if (acc === 1'b1) begin
        push_exp(2'd0, 32'hCAFE_0001);
        accepts++;
      end
      prev_acc = acc;
      tick();
    end
    req_valid[1] = 1'b0;
    check("l0/accept_count", 32'(accepts), 32'd4);
    check("l0/sb_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
